aes_round_sequencer: RTL and testbench

Iterative controller that time-shares one AES round datapath across all NR rounds of a block. The datapath is SubBytes/ShiftRows/MixColumns/AddRoundKey, or its inverse, built from MixColumns/MixColumnsInverse. The sequencer:
- accepts a 128-bit block with a valid/ready handshake;
- performs the initial AddRoundKey whitening;
- loops the state through the external datapath once per cycle, driving round-key index, direction and final-round MixColumns bypass;
- presents the result with a valid/ready handshake.

It sits between the block I/O interface and the round datapath/key-schedule ROM in the processor top.

---
 rtl/AESDefinitions.sv | 21 ++
 rtl/aes_round_counter.sv | 56 +++++
 rtl/aes_round_sequencer.sv | 134 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/AESDefinitions.sv
// Shared types and constants for the iterative AES round sequencer.
package AESDefinitions;

  typedef logic [127:0] state_t;
  typedef logic [127:0] roundkey_t;

  localparam int unsigned NR_128 = 32'd10;
  localparam int unsigned NR_192 = 32'd12;
  localparam int unsigned NR_256 = 32'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  function automatic logic nr_legal(input int unsigned nr);
    return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round counter for the AES sequencer: tracks 1..NR and derives the
// round-key index from the latched direction.
module aes_round_counter
  import AESDefinitions::*;
#(
  parameter int unsigned NR     = NR_128,
  parameter int unsigned KIDX_W = 32'd4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic              i_load_phase,
  input  logic              i_in_round,
  input  logic              i_dir,
  input  logic              i_in_decrypt,
  output logic              o_last,
  output logic [KIDX_W-1:0] o_rk_index
);

  localparam logic [KIDX_W-1:0] LP_NR  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] LP_ONE = KIDX_W'(32'd1);

  logic [KIDX_W-1:0] r_rnd;
  logic [KIDX_W-1:0] w_rk_index;

  // Counter saturates at NR; the FSM leaves ROUND on that same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rnd <= '0;
    end else if (i_load) begin
      r_rnd <= LP_ONE;
    end else if (i_inc && !o_last) begin
      r_rnd <= r_rnd + LP_ONE;
    end else begin
      r_rnd <= r_rnd;
    end
  end

  assign o_last = (r_rnd == LP_NR);

  // Whitening key comes from the offered block's direction, round keys from the latched one.
  always_comb begin
    w_rk_index = '0;
    if (i_load_phase) begin
      w_rk_index = i_in_decrypt ? LP_NR : '0;
    end else if (i_in_round) begin
      w_rk_index = i_dir ? (LP_NR - r_rnd) : r_rnd;
    end else begin
      w_rk_index = '0;
    end
  end

  assign o_rk_index = w_rk_index;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: whitens an accepted block, then loops it through
// an external round datapath once per cycle and hands the result out.
module aes_round_sequencer
  import AESDefinitions::*;
#(
  parameter int unsigned NR     = NR_128,
  parameter int unsigned KIDX_W = 32'd4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  state_t            in_data,
  input  logic              in_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output state_t            out_data,
  output logic [KIDX_W-1:0] rk_index,
  input  roundkey_t         rk_data,
  output state_t            dp_state,
  output logic              dp_decrypt,
  output logic              dp_final,
  input  state_t            dp_result,
  output logic              busy
);

  if (!nr_legal(NR) || ((64'd1 << KIDX_W) <= 64'(NR))) begin : g_bad_param
    $error("aes_round_sequencer: NR must be 10/12/14 and fit in KIDX_W bits");
  end

  seq_state_t r_state;
  seq_state_t w_next;
  state_t     r_state_reg;
  logic       r_dir;
  logic       w_accept;
  logic       w_ready;
  logic       w_last;
  logic       w_in_round;
  logic       w_load_phase;

  assign w_in_round   = (r_state == ROUND);
  assign w_load_phase = reset_n && (r_state != ROUND);

  aes_round_counter #(
    .NR     (NR),
    .KIDX_W (KIDX_W)
  ) u_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_load       (w_accept),
    .i_inc        (w_in_round),
    .i_load_phase (w_load_phase),
    .i_in_round   (w_in_round),
    .i_dir        (r_dir),
    .i_in_decrypt (in_decrypt),
    .o_last       (w_last),
    .o_rk_index   (rk_index)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake; DONE can take a new block in the cycle its result leaves.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_ready   = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ROUND;
        end else begin
          w_next = IDLE;
        end
      end
      ROUND: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = ROUND;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        w_ready   = out_ready;
        if (out_ready && in_valid) begin
          w_accept = 1'b1;
          w_next   = ROUND;
        end else if (out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Block state and per-block direction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state_reg <= '0;
      r_dir       <= 1'b0;
    end else if (w_accept) begin
      r_state_reg <= in_data ^ rk_data;
      r_dir       <= in_decrypt;
    end else if (w_in_round) begin
      r_state_reg <= dp_result;
      r_dir       <= r_dir;
    end else begin
      r_state_reg <= r_state_reg;
      r_dir       <= r_dir;
    end
  end

  assign in_ready   = reset_n && w_ready;
  assign out_data   = (r_state == DONE) ? r_state_reg : '0;
  assign dp_state   = r_state_reg;
  assign dp_decrypt = w_in_round && r_dir;
  assign dp_final   = w_in_round && w_last;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round and
// key-schedule ROM; NR=10 and NR=14 instances.
module tb_aes_round_sequencer;
  import AESDefinitions::*;

  typedef logic [127:0] rks_t [0:15];

  localparam state_t            PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam state_t            CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0]      KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam state_t            PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam state_t            CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0]      KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0]      KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam state_t            CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic iv10, ir10, idec10, ov10, ordy10, dpd10, dpf10, busy10, ksel10;
  state_t id10, od10, dps10, dpr10;
  logic [3:0] rki10;
  roundkey_t rkd10;

  logic iv14, ir14, idec14, ov14, ordy14, dpd14, dpf14, busy14;
  state_t id14, od14, dps14, dpr14;
  logic [3:0] rki14;
  roundkey_t rkd14;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox  [0:255];
  logic [7:0] isbox [0:255];
  rks_t rk_a, rk_b, rk_c;

  aes_round_sequencer #(.NR(32'd10), .KIDX_W(32'd4)) u10 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv10), .in_ready(ir10), .in_data(id10),
    .in_decrypt(idec10), .out_valid(ov10), .out_ready(ordy10), .out_data(od10),
    .rk_index(rki10), .rk_data(rkd10), .dp_state(dps10), .dp_decrypt(dpd10),
    .dp_final(dpf10), .dp_result(dpr10), .busy(busy10)
  );

  aes_round_sequencer #(.NR(32'd14), .KIDX_W(32'd4)) u14 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv14), .in_ready(ir14), .in_data(id14),
    .in_decrypt(idec14), .out_valid(ov14), .out_ready(ordy14), .out_data(od14),
    .rk_index(rki14), .rk_data(rkd14), .dp_state(dps14), .dp_decrypt(dpd14),
    .dp_final(dpf14), .dp_result(dpr14), .busy(busy14)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // One AES round (or inverse round); the final round skips (Inv)MixColumns.
  function automatic state_t dp_model(input state_t s, input roundkey_t k, input logic dec, input logic fin);
    logic [7:0] a [0:15];
    logic [7:0] t [0:15];
    logic [7:0] a0, a1, a2, a3;
    state_t res;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    if (!dec) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = sbox[a[r+4*((c+r)%4)]];
      if (!fin) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*((c+r)%4)] = isbox[a[r+4*c]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
      if (!fin) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          t[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          t[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          t[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr, output rks_t rk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else rk[r] = '0;
    end
  endtask

  // Key ROM: App.B key serves encryption, App.C.1 key serves decryption.
  always_comb begin
    ksel10 = (busy10 && !ov10) ? dpd10 : idec10;
    rkd10  = ksel10 ? rk_b[rki10] : rk_a[rki10];
    dpr10  = dp_model(dps10, rkd10, dpd10, dpf10);
  end

  always_comb begin
    rkd14 = rk_c[rki14];
    dpr14 = dp_model(dps14, rkd14, dpd14, dpf14);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic rounds10(input logic dec, input string tag);
    for (int k = 1; k <= 10; k++) begin
      check({tag, "_rk"}, 128'(rki10), dec ? 128'(10 - k) : 128'(k));
      check({tag, "_final"}, 128'(dpf10), 128'(k == 10));
      check({tag, "_ov_ir_busy"}, 128'({ov10, ir10, busy10}), 128'(3'b001));
      step();
    end
  endtask

  initial begin
    reset_n = 1'b1;
    iv10 = 1'b0; idec10 = 1'b0; ordy10 = 1'b0; id10 = '0;
    iv14 = 1'b0; idec14 = 1'b0; ordy14 = 1'b0; id14 = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    expand({KEY_A, 128'h0}, 4, 10, rk_a);
    expand({KEY_B, 128'h0}, 4, 10, rk_b);
    expand(KEY_C, 8, 14, rk_c);

    #2 reset_n = 1'b0;
    #1;
    check("rst_flags", 128'({ir10, ov10, busy10, dpf10, dpd10}), 128'(5'b00000));
    check("rst_out_data", od10, 128'h0);
    check("rst_rk_index", 128'(rki10), 128'h0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("idle_ready", 128'({ir10, ov10, busy10}), 128'(3'b100));

    // App.B encrypt with backpressure
    iv10 = 1'b1; id10 = PT_A; idec10 = 1'b0;
    #1;
    check("encA_accept_ready", 128'(ir10), 128'(1'b1));
    check("encA_accept_rk", 128'(rki10), 128'h0);
    step();
    iv10 = 1'b0; idec10 = 1'b1;
    rounds10(1'b0, "encA");
    check("encA_out_valid", 128'(ov10), 128'(1'b1));
    check("encA_out_data", od10, CT_A);
    for (int j = 0; j < 5; j++) begin
      check("bp_valid_ready", 128'({ov10, ir10, dpf10}), 128'(3'b100));
      check("bp_data", od10, CT_A);
      step();
    end
    ordy10 = 1'b1;
    #1;
    check("bp_release_ready", 128'(ir10), 128'(1'b1));
    step();
    check("bp_idle", 128'({ov10, busy10, ir10}), 128'(3'b001));
    check("bp_idle_data", od10, 128'h0);
    ordy10 = 1'b0;

    // App.C.1 decrypt
    iv10 = 1'b1; id10 = CT_B; idec10 = 1'b1;
    #1;
    check("decB_accept_rk", 128'(rki10), 128'(10));
    step();
    iv10 = 1'b0; idec10 = 1'b0;
    rounds10(1'b1, "decB");
    check("decB_out_valid", 128'(ov10), 128'(1'b1));
    check("decB_out_data", od10, PT_B);
    ordy10 = 1'b1;
    step();
    check("decB_idle", 128'({ov10, busy10}), 128'(2'b00));

    // Back-to-back encrypt then decrypt
    iv10 = 1'b1; id10 = PT_A; idec10 = 1'b0;
    #1;
    check("b2b_accept_ready", 128'(ir10), 128'(1'b1));
    step();
    id10 = CT_B; idec10 = 1'b1;
    rounds10(1'b0, "b2bA");
    check("b2bA_out", od10, CT_A);
    check("b2bA_handshake", 128'({ov10, ir10}), 128'(2'b11));
    check("b2bB_accept_rk", 128'(rki10), 128'(10));
    step();
    iv10 = 1'b0;
    rounds10(1'b1, "b2bB");
    check("b2bB_out_valid", 128'(ov10), 128'(1'b1));
    check("b2bB_out", od10, PT_B);
    step();
    check("b2b_idle", 128'({ov10, busy10}), 128'(2'b00));
    ordy10 = 1'b0;

    // Reset in round 5
    iv10 = 1'b1; id10 = PT_A; idec10 = 1'b0;
    #1;
    step();
    iv10 = 1'b0;
    repeat (4) step();
    check("rst_mid_round5_rk", 128'(rki10), 128'(5));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_flags", 128'({ov10, ir10, busy10, dpf10}), 128'(4'b0000));
    check("rst_mid_rk", 128'(rki10), 128'h0);
    step();
    reset_n = 1'b1;
    #1;
    check("rst_mid_release", 128'({ir10, busy10, ov10}), 128'(3'b100));
    for (int j = 0; j < 12; j++) begin
      check("rst_mid_no_out", 128'(ov10), 128'(1'b0));
      step();
    end
    iv10 = 1'b1; id10 = PT_A; idec10 = 1'b0;
    #1;
    step();
    iv10 = 1'b0;
    rounds10(1'b0, "postrst");
    check("postrst_out", od10, CT_A);
    check("postrst_valid", 128'(ov10), 128'(1'b1));
    ordy10 = 1'b1;
    step();
    ordy10 = 1'b0;

    // NR=14 AES-256
    iv14 = 1'b1; id14 = PT_B; idec14 = 1'b0;
    #1;
    check("aes256_accept", 128'({ir14, rki14}), 128'(5'b10000));
    step();
    iv14 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check("aes256_rk", 128'(rki14), 128'(k));
      check("aes256_final", 128'(dpf14), 128'(k == 14));
      check("aes256_no_out", 128'(ov14), 128'(1'b0));
      step();
    end
    check("aes256_out_valid", 128'(ov14), 128'(1'b1));
    check("aes256_out", od14, CT_C);
    ordy14 = 1'b1;
    step();
    check("aes256_idle", 128'({ov14, busy14}), 128'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
